// File: rtl/aes_cipher_iter_if.sv
// Handshake and data bus of the iterative AES encryption core.
// Width of words follows the key-size selector x (Nr+1 round keys of 128 bits).
interface aes_cipher_iter_if #(
    parameter int x = 0
);
    logic                        start;
    logic [0:127]                in;
    logic [0:128*(2*x+11)-1]     words;
    logic [0:127]                out;
    logic                        busy;
    logic                        done;

    modport master (output start, in, words, input out, busy, done);
    modport slave  (input start, in, words, output out, busy, done);
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock, pre-expanded round keys on a flat bus.
// Define AES_CIPHER_KEY_LATCH_EN to capture all round keys on the accepting edge.
module aes_cipher_iter #(
    parameter int x = 0
) (
    input  logic              clk,
    input  logic              rst,
    aes_cipher_iter_if.slave  bus
);
    localparam int NR      = 10 + 2 * x;
    localparam int NK_BITS = 128 * (NR + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [0:0]         fsm;
    logic [3:0]         round;
    logic [0:127]       state;
    logic [0:127]       rk;
    logic [0:NK_BITS-1] key_src;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // State byte i sits at column i/4, row i%4; ShiftRows rotates row r left by r.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = SBOX[8*int'(s[8*(r+4*((c+r)%4)) +: 8]) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

`ifdef AES_CIPHER_KEY_LATCH_EN
    logic [0:NK_BITS-1] key_reg;

    // Round key 0 is consumed straight from the bus on the accepting edge,
    // so the latched copy only has to serve rounds 1..Nr.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
        end else if (fsm == IDLE && bus.start) begin
            key_reg <= bus.words;
        end
    end

    assign key_src = key_reg;
`else
    assign key_src = bus.words;
`endif

    assign rk = key_src[128*int'(round) +: 128];

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            round    <= 4'd0;
            state    <= '0;
            bus.out  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        state    <= bus.in ^ bus.words[0 +: 128];
                        round    <= 4'd1;
                        bus.busy <= 1'b1;
                        fsm      <= RUN;
                    end
                end
                default: begin
                    if (round == 4'(NR)) begin
                        bus.out  <= sub_shift(state) ^ rk;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        round    <= 4'd0;
                        fsm      <= IDLE;
                    end else begin
                        state <= mix_columns(sub_shift(state)) ^ rk;
                        round <= round + 4'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter using FIPS-197 appendix C vectors for all three key sizes.
// Round keys are expanded here from an S-box derived arithmetically (GF(2^8) inverse + affine map).
module tb_aes_cipher_iter;
    logic clk;
    logic rst;

    aes_cipher_iter_if #(.x(0)) if0 ();
    aes_cipher_iter_if #(.x(1)) if1 ();
    aes_cipher_iter_if #(.x(2)) if2 ();

    aes_cipher_iter #(.x(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    aes_cipher_iter #(.x(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    aes_cipher_iter #(.x(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:255] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    int           nassert = 0;
    int           nfail   = 0;
    logic [7:0]   sb [256];
    logic [0:1919] ks0, ks1, ks2;

    logic         dn [3];
    logic         by [3];
    logic [0:127] ot [3];

    assign dn[0] = if0.done;  assign by[0] = if0.busy;  assign ot[0] = if0.out;
    assign dn[1] = if1.done;  assign by[1] = if1.busy;  assign ot[1] = if1.out;
    assign dn[2] = if2.done;  assign by[2] = if2.busy;  assign ot[2] = if2.out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input int nk, input logic [0:255] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [0:1919] r  = '0;
        int            nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [0:127] obs, input logic [0:127] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v, input logic [0:127] p);
        case (d)
            0: begin if0.start = v; if0.in = p; end
            1: begin if1.start = v; if1.in = p; end
            default: begin if2.start = v; if2.in = p; end
        endcase
    endtask

    // One start pulse, then measure edges to done and busy-high cycles.
    task automatic encrypt(input int d, input logic [0:127] ct, input int nr, input string tag);
        int kdone = -1;
        int nbusy = 0;
        @(negedge clk);
        set_start(d, 1'b1, PT);
        @(posedge clk);
        @(negedge clk);
        set_start(d, 1'b0, ~PT);
        for (int k = 0; k < 40; k++) begin
            if (dn[d]) begin
                kdone = k;
                break;
            end
            if (by[d]) nbusy++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 128'(kdone), 128'(nr));
        check({tag, "_busy_cycles"}, 128'(nbusy), 128'(nr));
        check({tag, "_out"}, ot[d], ct);
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(dn[d]), 128'd0);
    endtask

    initial begin
        int ndone, kdone, kd1, kd2, nlow;
        logic [0:127] o1, o2;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        ks0 = expand(4, KEY);
        ks1 = expand(6, KEY);
        ks2 = expand(8, KEY);

        rst = 1'b1;
        if0.start = 1'b0; if0.in = '0; if0.words = ks0[0:1407];
        if1.start = 1'b0; if1.in = '0; if1.words = ks1[0:1663];
        if2.start = 1'b0; if2.in = '0; if2.words = ks2[0:1919];
        repeat (2) @(negedge clk);
        check("reset_out", if0.out, '0);
        check("reset_busy", 128'(if0.busy), 128'd0);
        check("reset_done", 128'(if0.done), 128'd0);
        rst = 1'b0;

        $display("[TB] FIPS-197 vectors, all key sizes");
        encrypt(0, CT0, 10, "aes128");
        encrypt(1, CT1, 12, "aes192");
        encrypt(2, CT2, 14, "aes256");

        $display("[TB] start while busy is ignored");
        @(negedge clk);
        set_start(0, 1'b1, PT);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, PT);
        ndone = 0; kdone = -1;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) set_start(0, 1'b1, ~PT);
            if (k == 5) set_start(0, 1'b0, ~PT);
            if (if0.done) begin
                ndone++;
                kdone = k;
                o1 = if0.out;
            end
            @(negedge clk);
        end
        check("ignored_done_count", 128'(ndone), 128'd1);
        check("ignored_latency", 128'(kdone), 128'd10);
        check("ignored_out", o1, CT0);
        check("ignored_idle_busy", 128'(if0.busy), 128'd0);

        $display("[TB] back-to-back blocks");
        set_start(0, 1'b1, PT);
        @(posedge clk);
        @(negedge clk);
        kd1 = -1; kd2 = -1; nlow = 0; o1 = '0; o2 = '0;
        for (int k = 0; k <= 22; k++) begin
            if (if0.done) begin
                if (kd1 < 0) begin kd1 = k; o1 = if0.out; end
                else begin kd2 = k; o2 = if0.out; end
            end
            if (k < 21 && !if0.busy) nlow++;
            if (k == 11) set_start(0, 1'b0, PT);
            @(negedge clk);
        end
        check("b2b_first_done", 128'(kd1), 128'd10);
        check("b2b_second_done", 128'(kd2), 128'd21);
        check("b2b_first_out", o1, CT0);
        check("b2b_second_out", o2, CT0);
        check("b2b_busy_low_cycles", 128'(nlow), 128'd1);
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-run");
        set_start(0, 1'b1, PT);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, PT);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out", if0.out, '0);
        check("abort_busy", 128'(if0.busy), 128'd0);
        check("abort_done", 128'(if0.done), 128'd0);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (if0.done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", 128'(ndone), 128'd0);
        encrypt(0, CT0, 10, "after_abort");

        $display("[TB] reset and start on the same edge");
        rst = 1'b1;
        set_start(0, 1'b1, PT);
        @(negedge clk);
        check("rst_beats_start", 128'(if0.busy), 128'd0);
        rst = 1'b0;
        set_start(0, 1'b0, PT);

`ifdef AES_CIPHER_KEY_LATCH_EN
        $display("[TB] latched keys survive bus change");
        @(negedge clk);
        set_start(0, 1'b1, PT);
        @(posedge clk);
        @(negedge clk);
        set_start(0, 1'b0, PT);
        if0.words = '1;
        kdone = -1;
        for (int k = 0; k < 40; k++) begin
            if (if0.done) begin
                kdone = k;
                break;
            end
            @(negedge clk);
        end
        check("latch_latency", 128'(kdone), 128'd10);
        check("latch_out", if0.out, CT0);
        if0.words = ks0[0:1407];
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
